// File: rtl/rst_seq_sync.sv
// Reset synchroniser and sequencer: async assert, synchronous staged release
// of NUM_OUT resets with a settle time and fixed inter-output gap.
module rst_seq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_CYCLES  = 4,
  parameter int STEP_CYCLES = 3,
  parameter int NUM_OUT     = 3
) (
  input  logic               clk,
  input  logic               async_rst_n_i,
  input  logic               sw_rst_i,
  output logic [NUM_OUT-1:0] sync_rst_o,
  output logic               rst_done_o,
  output logic               rst_src_o
);

  localparam int MAXC = (MIN_CYCLES > STEP_CYCLES) ? MIN_CYCLES : STEP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = $clog2(NUM_OUT) + 1;
  localparam int CHW  = SYNC_STAGES - 1;

  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] STRETCH = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // The state flop leaving HOLD acts as the last synchroniser stage,
  // so the explicit chain is one flop shorter than SYNC_STAGES.
  logic [CHW-1:0]     chain_q, chain_d;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic               done_q, done_d;
  logic               src_q, src_d;

  always_comb begin
    chain_d = (chain_q << 1) | CHW'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    src_d   = src_q;

    case (state_q)
      HOLD: begin
        if (chain_q[CHW-1]) begin
          state_d = STRETCH;
          cnt_d   = '0;
        end
      end
      STRETCH: begin
        if (cnt_q == MIN_LAST) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          idx_d    = IW'(1);
          state_d  = (NUM_OUT == 1) ? DONE : RELEASE;
          done_d   = (NUM_OUT == 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == STEP_LAST) begin
          for (int k = 0; k < NUM_OUT; k++) begin
            if (idx_q == IW'(k)) rst_d[k] = 1'b0;
          end
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    // A held request keeps the counter parked at zero in STRETCH.
    if (sw_rst_i && (state_q != HOLD)) begin
      rst_d   = '1;
      done_d  = 1'b0;
      src_d   = 1'b1;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = STRETCH;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      chain_q <= '0;
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      src_q   <= src_d;
    end
  end

  assign sync_rst_o = rst_q;
  assign rst_done_o = done_q;
  assign rst_src_o  = src_q;

endmodule

// File: doc/rst_seq_sync.md
# rst_seq_sync

Parametrised reset synchroniser and sequencer: asserts all downstream resets asynchronously, deasserts them synchronously to `clk` after a programmable settle time, and releases `NUM_OUT` reset outputs one at a time in index order with a fixed gap. It sits at the top of each clock domain, between the board or PLL-lock reset and the domain's logic. A synchronous software reset request re-runs the same sequence without an external reset.

## Interface
- SYNC_STAGES, 2, synchroniser flop count on the reset deassertion path; legal ≥2
- MIN_CYCLES, 4, settle cycles between synchroniser release and release of output 0; legal ≥1
- STEP_CYCLES, 3, cycles between release of output k-1 and output k; legal ≥1
- NUM_OUT, 3, number of sequenced reset outputs; legal ≥1
- clk  input  1  domain clock; all flops are rising-edge
- async_rst_n_i  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronised internally
- sw_rst_i  input  1  synchronous, active-high software reset request (level, already in `clk` domain)
- sync_rst_o  output  NUM_OUT  active-high resets; bit k releases k·STEP_CYCLES after bit 0
- rst_done_o  output  1  high when every bit of sync_rst_o is released
- rst_src_o  output  1  sticky; 1 = the most recent reset sequence was started by sw_rst_i

## Operation
- States: HOLD, STRETCH, RELEASE, DONE. A single counter (width $clog2(max(MIN_CYCLES,STEP_CYCLES))+1) and a release index (width $clog2(NUM_OUT)+1) are shared across states.
- async_rst_n_i low, immediately and without a clock: sync_rst_o all ones, rst_done_o=0, rst_src_o=0, synchroniser chain cleared, counter and index 0, state HOLD. All state flops use asynchronous set or clear; no combinational path from async_rst_n_i to any output.
- HOLD: the chain shifts in 1 each edge. When the chain output is 1, the state moves to STRETCH with counter 0.
- STRETCH: each edge with sw_rst_i=0 increments the counter. On the edge where counter==MIN_CYCLES-1, sync_rst_o[0] clears, the counter resets, and the state moves to RELEASE (or DONE when NUM_OUT=1).
- RELEASE: the counter counts to STEP_CYCLES-1. On that edge the next index bit clears. After bit NUM_OUT-1 clears, the state moves to DONE.
- DONE: rst_done_o=1, all outputs 0.
- Released bits stay released. An output never re-asserts except through async reset or sw_rst_i.
- sw_rst_i sampled 1 in any state other than HOLD:
  - at that edge, all sync_rst_o bits are set, rst_done_o=0, rst_src_o=1, counter 0, state STRETCH;
  - while sw_rst_i stays 1, the counter holds at 0.
- sw_rst_i during HOLD is ignored. Async reset has priority over everything.
- async_rst_n_i asserting mid-sequence aborts immediately to HOLD. The full sequence restarts from chain fill.
- rst_src_o is cleared only by async reset.

## Timing
- Reset values: sync_rst_o = all ones, rst_done_o = 0, rst_src_o = 0.
- Edge 1 is the first rising edge with async_rst_n_i high (recovery met).
- After async reset release:
  - chain output is 1 after edge SYNC_STAGES;
  - sync_rst_o[0] clears at edge SYNC_STAGES+MIN_CYCLES;
  - sync_rst_o[k] clears at edge SYNC_STAGES+MIN_CYCLES+k·STEP_CYCLES;
  - rst_done_o rises on the same edge as the last bit clears.
- After software reset: if g is the first edge with sw_rst_i sampled 0 after a request, bit 0 clears at edge g+MIN_CYCLES-1 and bit k at g+MIN_CYCLES-1+k·STEP_CYCLES.
- Deassertion of every output is glitch-free and driven directly from a flop.

## Test plan
- Defaults (2/4/3/3), release async_rst_n_i before edge 1 -> sync_rst_o goes 111→110 at edge 6, 100 at edge 9, 000 at edge 12; rst_done_o=1 from edge 12; rst_src_o=0.
- async_rst_n_i low for 3 ns between edges while in DONE -> sync_rst_o=111 and rst_done_o=0 before the next edge; sequence replays with release edges 6/9/12 counted from the next release.
- sw_rst_i high for edges 20–22 while in DONE -> sync_rst_o=111 after edge 20, rst_src_o=1; first low edge 23; bits clear at edges 26, 29, 32.
- sw_rst_i pulse at edge 10 (mid-RELEASE, sync_rst_o=110) -> all bits re-asserted at edge 10, bit 1 does not release early, bit 0 clears at edge 14.
- async_rst_n_i asserted at edge 8 (during RELEASE) -> immediate 111 and HOLD; rst_src_o cleared to 0.
- NUM_OUT=1, SYNC_STAGES=3, MIN_CYCLES=1 -> sync_rst_o[0] and rst_done_o change at edge 4.
